// File: rtl/instr_fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// Requests are issued on req & gnt; responses return in request order.
interface instr_fetch_unit_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        ibus_err;

    modport master (
        output ibus_req, ibus_addr,
        input  ibus_gnt, ibus_rvalid, ibus_rdata, ibus_err
    );

    modport slave (
        input  ibus_req, ibus_addr,
        output ibus_gnt, ibus_rvalid, ibus_rdata, ibus_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: in-order bus requests, prefetch FIFO with PC tags,
// redirect flush with exact discard of stale in-flight responses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | fetching; requests issued while credit and discard allow
//   ST_HALT | exception entry pushed; no requests until next redirect
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_b,
    instr_fetch_unit_if.master ibus,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instruction,
    output logic [31:0]        out_pc,
    output logic               out_exc_misaligned,
    output logic               out_exc_bus_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
        logic        berr;
    } entry_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] pcq_wr_q, pcq_rd_q;
    logic [AW-1:0] fifo_wr_q, fifo_rd_q;
    logic [31:0]   pcq_mem  [FIFO_DEPTH];
    entry_t        fifo_mem [FIFO_DEPTH];

    entry_t head, push_entry;
    logic   issue, resp_drop, resp_take, mis_push, push, pop, halt_now;

    assign head               = fifo_mem[fifo_rd_q];
    assign out_valid          = (fifo_cnt_q != '0);
    assign out_instruction    = out_valid ? head.instr : NOP_INSTR;
    assign out_pc             = out_valid ? head.pc    : 32'h0;
    assign out_exc_misaligned = out_valid & head.mis;
    assign out_exc_bus_err    = out_valid & head.berr;

    assign pop       = out_valid & out_ready;
    assign resp_drop = ibus.ibus_rvalid & (discard_q != '0);
    assign resp_take = ibus.ibus_rvalid & (discard_q == '0) & (outst_q != '0);
    assign mis_push  = (state_q == ST_RUN) & (fetch_pc_q[1:0] != 2'b00);
    assign push      = ~redirect & (resp_take | mis_push);
    assign halt_now  = (resp_take & ibus.ibus_err) | mis_push;

    // A pop in the same cycle frees a slot, so back-to-back fetch keeps 1 instr/cycle.
    assign ibus.ibus_req  = rst_b & (state_q == ST_RUN) & ~redirect & (discard_q == '0)
                          & ~mis_push
                          & (({1'b0, outst_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop}) < DEPTH_L);
    assign ibus.ibus_addr = fetch_pc_q;
    assign issue          = ibus.ibus_req & ibus.ibus_gnt;

    always_comb begin
        push_entry = '{instr: NOP_INSTR, pc: fetch_pc_q, mis: 1'b1, berr: 1'b0};
        if (resp_take) begin
            push_entry.instr = ibus.ibus_err ? NOP_INSTR : ibus.ibus_rdata;
            push_entry.pc    = pcq_mem[pcq_rd_q];
            push_entry.mis   = 1'b0;
            push_entry.berr  = ibus.ibus_err;
        end
    end

    always_comb begin
        outst_d    = outst_q + CW'(issue) - CW'(resp_take);
        discard_d  = discard_q - CW'(resp_drop);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            outst_d    = '0;
            discard_d  = discard_q + outst_q - CW'(resp_drop) - CW'(resp_take);
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_VECTOR;
            outst_q    <= '0;
            discard_q  <= '0;
            fifo_cnt_q <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
        end else begin
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (redirect) begin
                state_q    <= ST_RUN;
                fetch_pc_q <= redirect_pc;
                pcq_wr_q   <= '0;
                pcq_rd_q   <= '0;
                fifo_wr_q  <= '0;
                fifo_rd_q  <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                    pcq_wr_q   <= pcq_wr_q + AW'(1);
                end
                if (resp_take) pcq_rd_q  <= pcq_rd_q + AW'(1);
                if (push)      fifo_wr_q <= fifo_wr_q + AW'(1);
                if (pop)       fifo_rd_q <= fifo_rd_q + AW'(1);
                case (state_q)
                    ST_RUN:  if (halt_now) state_q <= ST_HALT;
                    default: state_q <= ST_HALT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) pcq_mem[pcq_wr_q]   <= ibus.ibus_addr;
        if (push)  fifo_mem[fifo_wr_q] <= push_entry;
    end

    // A response with nothing in flight is a bus protocol violation.
    assert property (@(posedge clk) disable iff (!rst_b)
        ibus.ibus_rvalid |-> ((outst_q != '0) || (discard_q != '0)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with programmable latency,
// grant budget and error address; scoreboard queue checked by an output monitor.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instruction, out_pc;
    logic        out_exc_misaligned, out_exc_bus_err;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .FIFO_DEPTH  (2),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .ibus              (bus),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instruction   (out_instruction),
        .out_pc            (out_pc),
        .out_exc_misaligned(out_exc_misaligned),
        .out_exc_bus_err   (out_exc_bus_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int grant_limit = 0;
    int lat = 1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
        logic        berr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bresp_t;

    exp_t   exp_q[$];
    bresp_t bq[$];
    int     pop_cyc[$];

    assign bus.ibus_gnt = (issue_cnt < grant_limit);

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] instr, input logic [31:0] pc,
                            input logic mis, input logic berr);
        exp_t e;
        e.instr = instr; e.pc = pc; e.mis = mis; e.berr = berr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic wait_empty(input int maxc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_issues(input int target, input int maxc, input string name);
        int n;
        n = 0;
        while (issue_cnt < target && n < maxc) begin
            tick();
            n++;
        end
        check({name, "_issued"}, issue_cnt, target);
    endtask

    // Memory: sample at the edge, drive the next cycle's response 1 time unit later.
    initial begin
        logic        s_req, s_gnt, s_rst;
        logic [31:0] s_addr;
        int          d, last_due;
        bresp_t      r;
        last_due = 0;
        bus.ibus_rvalid = 1'b0;
        bus.ibus_rdata  = 32'h0;
        bus.ibus_err    = 1'b0;
        forever begin
            @(posedge clk);
            s_rst  = rst_b;
            s_req  = bus.ibus_req;
            s_gnt  = bus.ibus_gnt;
            s_addr = bus.ibus_addr;
            cyc++;
            #1;
            if (!s_rst || !rst_b) begin
                bq.delete();
                bus.ibus_rvalid = 1'b0;
                bus.ibus_err    = 1'b0;
            end else begin
                if (s_req && s_gnt) begin
                    issue_cnt++;
                    d = cyc + lat;
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    r.addr = s_addr;
                    r.due  = d;
                    bq.push_back(r);
                end
                if (bq.size() != 0 && bq[0].due == cyc + 1) begin
                    r = bq.pop_front();
                    bus.ibus_rvalid = 1'b1;
                    bus.ibus_rdata  = mem_word(r.addr);
                    bus.ibus_err    = err_en && (r.addr == err_addr);
                end else begin
                    bus.ibus_rvalid = 1'b0;
                    bus.ibus_rdata  = 32'hDEAD_BEEF;
                    bus.ibus_err    = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted instruction is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b && out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got pc %h instr %h, required no output",
                             out_pc, out_instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instruction", out_instruction, e.instr);
                    check("out_pc", out_pc, e.pc);
                    check("out_exc_flags", {30'b0, out_exc_misaligned, out_exc_bus_err},
                          {30'b0, e.mis, e.berr});
                end
            end
        end
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n, base;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_ibus_req", bus.ibus_req, 0);
        check("rst_ibus_addr", bus.ibus_addr, 32'h0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instruction", out_instruction, NOP);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_exc_flags", {out_exc_misaligned, out_exc_bus_err}, 0);

        // Streaming after reset release, 1-cycle latency
        grant_limit = 4;
        out_ready   = 1'b1;
        for (int i = 0; i < 4; i++) exp_push(i, 32'(i * 4), 1'b0, 1'b0);
        pop_cyc.delete();
        rst_b = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("first_valid_edges", n, 2);
        wait_empty(20, "t1");
        check("t1_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("t1_back_to_back", pop_cyc[3] - pop_cyc[0], 3);

        // Decode stall: only FIFO_DEPTH requests, head held stable
        repeat (3) tick();
        out_ready   = 1'b0;
        base        = issue_cnt;
        grant_limit = base + 4;
        for (int i = 0; i < 4; i++) exp_push(i, 32'(i * 4), 1'b0, 1'b0);
        do_redirect(32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 3) begin
                check("t2_req_full", bus.ibus_req, 0);
                check("t2_valid_held", out_valid, 1);
                check("t2_pc_held", out_pc, 32'h0);
            end
        end
        check("t2_issues", issue_cnt - base, 2);
        out_ready = 1'b1;
        wait_empty(30, "t2");

        // Redirect with two requests in flight, 3-cycle latency
        repeat (3) tick();
        base        = issue_cnt;
        lat         = 3;
        grant_limit = base + 2;
        wait_issues(base + 2, 20, "t3");
        for (int i = 0; i < 3; i++)
            exp_push(mem_word(32'h100 + 32'(i * 4)), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        grant_limit = base + 5;
        do_redirect(32'h100);
        check("t3_valid_after_redirect", out_valid, 0);
        wait_empty(40, "t3");

        // Misaligned redirect, then resume
        repeat (3) tick();
        base        = issue_cnt;
        lat         = 1;
        grant_limit = base + 5;
        exp_push(NOP, 32'h102, 1'b1, 1'b0);
        do_redirect(32'h102);
        check("t4_valid_next", out_valid, 0);
        check("t4_req_next", bus.ibus_req, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_req_halt", bus.ibus_req, 0);
        end
        check("t4_no_issue", issue_cnt - base, 0);
        wait_empty(10, "t4");
        grant_limit = base + 2;
        exp_push(mem_word(32'h200), 32'h200, 1'b0, 1'b0);
        exp_push(mem_word(32'h204), 32'h204, 1'b0, 1'b0);
        do_redirect(32'h200);
        wait_empty(30, "t4b");

        // Bus error at 0x8; the already-issued 0xC is still delivered, then halt
        repeat (3) tick();
        base        = issue_cnt;
        grant_limit = base + 10;
        err_addr    = 32'h8;
        err_en      = 1'b1;
        exp_push(32'h0, 32'h0, 1'b0, 1'b0);
        exp_push(32'h1, 32'h4, 1'b0, 1'b0);
        exp_push(NOP,   32'h8, 1'b0, 1'b1);
        exp_push(32'h3, 32'hC, 1'b0, 1'b0);
        do_redirect(32'h0);
        wait_empty(30, "t5");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_req_halt", bus.ibus_req, 0);
        end
        check("t5_issues", issue_cnt - base, 4);
        err_en = 1'b0;

        // Reset with two requests outstanding
        base        = issue_cnt;
        lat         = 3;
        grant_limit = base + 2;
        do_redirect(32'h40);
        wait_issues(base + 2, 20, "t6");
        rst_b = 1'b0;
        #1;
        check("t6_rst_req", bus.ibus_req, 0);
        check("t6_rst_addr", bus.ibus_addr, 32'h0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_instruction", out_instruction, NOP);
        check("t6_rst_pc", out_pc, 32'h0);
        tick();
        tick();
        lat         = 1;
        base        = issue_cnt;
        grant_limit = base + 2;
        exp_push(32'h0, 32'h0, 1'b0, 1'b0);
        exp_push(32'h1, 32'h4, 1'b0, 1'b0);
        rst_b = 1'b1;
        #1;
        check("t6_restart_req", bus.ibus_req, 1);
        check("t6_restart_addr", bus.ibus_addr, 32'h0);
        wait_empty(30, "t6");
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
